// File: rtl/expand_buffer_pkg.sv
// Shared defaults, pointer/count widths and the popcount helper used by the
// compaction and expansion sides of the lane network.
package expand_buffer_pkg;

  localparam int NUM_LANE_DEF  = 8;
  localparam int DATA_SIZE_DEF = 4;
  localparam int BUF_DEPTH_DEF = 16;
  localparam int PTR_W         = $clog2(BUF_DEPTH_DEF);
  localparam int CNT_W         = PTR_W + 1;

  // Callers zero-extend their mask to 64 bits and truncate the result.
  function automatic int unsigned popcount(input logic [63:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < 64; i++) begin
      c = c + {31'd0, v[i]};
    end
    return c;
  endfunction

endpackage

// File: rtl/expand_buffer_prefix_sum.sv
// Exclusive prefix sum over NUM_ELEM fields: element i receives the sum of
// fields 0..i-1.
module expand_buffer_prefix_sum #(
  parameter int NUM_ELEM    = 8,
  parameter int INPUT_SIZE  = 1,
  parameter int OUTPUT_SIZE = 4
) (
  input  logic [NUM_ELEM*INPUT_SIZE-1:0]  in_val,
  output logic [NUM_ELEM*OUTPUT_SIZE-1:0] out_sum
);

  logic [OUTPUT_SIZE-1:0] acc;

  always_comb begin
    acc     = '0;
    out_sum = '0;
    for (int i = 0; i < NUM_ELEM; i++) begin
      out_sum[i*OUTPUT_SIZE +: OUTPUT_SIZE] = acc;
      acc = acc + OUTPUT_SIZE'(in_val[i*INPUT_SIZE +: INPUT_SIZE]);
    end
  end

endmodule

// File: rtl/expand_buffer.sv
// Circular buffer that takes densely packed groups and scatters the oldest
// entries, in order, onto the lowest-index free destination slots.
module expand_buffer
  import expand_buffer_pkg::*;
#(
  parameter int NUM_LANE  = NUM_LANE_DEF,
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int BUF_DEPTH = BUF_DEPTH_DEF
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_LANE-1:0]           in_vld,
  input  logic [NUM_LANE*DATA_SIZE-1:0] in_data,
  output logic                          in_rdy,
  input  logic [NUM_LANE-1:0]           slot_free,
  output logic [NUM_LANE-1:0]           out_vld,
  output logic [NUM_LANE*DATA_SIZE-1:0] out_data,
  output logic [$clog2(BUF_DEPTH):0]    count,
  output logic                          err_noncontig
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int LW = $clog2(NUM_LANE) + 1;

  logic [DATA_SIZE-1:0] mem_q [BUF_DEPTH];
  logic [DATA_SIZE-1:0] mem_d [BUF_DEPTH];
  logic [PW-1:0]        head_q, head_d;
  logic [PW-1:0]        tail_q, tail_d;
  logic [CW-1:0]        count_q, count_d;
  logic                 err_q, err_d;

  logic [NUM_LANE*LW-1:0] pfx;
  logic                   contig, push, viol;
  logic [LW-1:0]          n_in, n_free;
  logic [CW-1:0]          n_out;

  expand_buffer_prefix_sum #(
    .NUM_ELEM    (NUM_LANE),
    .INPUT_SIZE  (1),
    .OUTPUT_SIZE (LW)
  ) u_slot_pfx (
    .in_val  (slot_free),
    .out_sum (pfx)
  );

  // Adding one to a prefix mask clears exactly its ones, so any leftover
  // overlap means a hole in the valid mask.
  assign contig = ((in_vld & (in_vld + NUM_LANE'(1))) == '0);
  assign in_rdy = rst_n && ((CW'(BUF_DEPTH) - count_q) >= CW'(NUM_LANE));
  assign push   = in_rdy && (|in_vld) && contig;
  assign viol   = in_rdy && (|in_vld) && !contig;
  assign n_in   = push ? LW'(popcount(64'(in_vld))) : '0;
  assign n_free = LW'(popcount(64'(slot_free)));
  assign n_out  = (CW'(n_free) < count_q) ? CW'(n_free) : count_q;

  always_comb begin
    out_vld  = '0;
    out_data = '0;
    for (int i = 0; i < NUM_LANE; i++) begin
      if (rst_n && slot_free[i] && (CW'(pfx[i*LW +: LW]) < count_q)) begin
        out_vld[i] = 1'b1;
        out_data[i*DATA_SIZE +: DATA_SIZE] = mem_q[head_q + PW'(pfx[i*LW +: LW])];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int k = 0; k < NUM_LANE; k++) begin
      if (LW'(k) < n_in) begin
        mem_d[tail_q + PW'(k)] = in_data[k*DATA_SIZE +: DATA_SIZE];
      end
    end
    head_d  = head_q + PW'(n_out);
    tail_d  = tail_q + PW'(n_in);
    count_d = count_q + CW'(n_in) - n_out;
    err_d   = err_q | viol;
  end

  // Storage is deliberately left out of reset; occupancy alone defines what is live.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
    if (!rst_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  assign count         = count_q;
  assign err_noncontig = err_q;

endmodule

// File: tb/tb_expand_buffer.sv
// Bench for expand_buffer: queue-based occupancy model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_expand_buffer;

  localparam int NL = 8;
  localparam int DS = 4;
  localparam int BD = 16;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NL-1:0]     in_vld;
  logic [NL*DS-1:0]  in_data;
  logic              in_rdy;
  logic [NL-1:0]     slot_free;
  logic [NL-1:0]     out_vld;
  logic [NL*DS-1:0]  out_data;
  logic [4:0]        count;
  logic              err_noncontig;

  always #5 clk = ~clk;

  expand_buffer #(.NUM_LANE(NL), .DATA_SIZE(DS), .BUF_DEPTH(BD)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_vld        (in_vld),
    .in_data       (in_data),
    .in_rdy        (in_rdy),
    .slot_free     (slot_free),
    .out_vld       (out_vld),
    .out_data      (out_data),
    .count         (count),
    .err_noncontig (err_noncontig)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: FIFO of buffered values, sticky error flag.
  logic [DS-1:0] q[$];
  logic [DS-1:0] nq[$];
  logic          m_err = 1'b0;
  logic          n_err = 1'b0;
  bit            started = 1'b0;

  always @(negedge clk) begin
    logic [NL-1:0]    ev;
    logic [NL*DS-1:0] ed, mask;
    logic             e_rdy;
    int               j, n;
    bit               ok;
    if (started) begin
      e_rdy = rst_n && ((BD - q.size()) >= NL);
      ev = '0; ed = '0; mask = '0; j = 0;
      if (rst_n) begin
        for (int i = 0; i < NL; i++) begin
          if (slot_free[i] && j < q.size()) begin
            ev[i] = 1'b1;
            ed[i*DS +: DS] = q[j];
            mask[i*DS +: DS] = '1;
            j++;
          end
        end
      end
      chk("in_rdy", in_rdy, e_rdy);
      chk("out_vld", out_vld, ev);
      chk("out_data", out_data & mask, ed);
      chk("count", count, q.size());
      chk("err_noncontig", err_noncontig, m_err);
      chk("vld_subset_of_free", out_vld & ~slot_free, 0);
      chk("count_le_depth", (count <= BD), 1);
      chk("head_plus_count_eq_tail", 4'(dut.head_q + dut.count_q), dut.tail_q);

      nq = q;
      for (int k = 0; k < j; k++) void'(nq.pop_front());
      n_err = m_err;
      if (e_rdy && in_vld != '0) begin
        ok = 0; n = 0;
        for (int m = 1; m <= NL; m++) begin
          if (int'(in_vld) == ((1 << m) - 1)) begin
            ok = 1; n = m;
          end
        end
        if (ok) begin
          for (int k = 0; k < n; k++) nq.push_back(in_data[k*DS +: DS]);
        end else begin
          n_err = 1'b1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
      m_err = 1'b0;
      started = 1'b1;
    end else if (started) begin
      q = nq;
      m_err = n_err;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NL-1:0] v, input logic [NL*DS-1:0] d, input logic [NL-1:0] sf);
    in_vld = v;
    in_data = d;
    slot_free = sf;
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 32'h0, 8'h00);
    tick();
    tick();
    rst_n = 1'b1;

    // Reset state
    @(negedge clk);
    chk("lit_reset_count", count, 0);
    chk("lit_reset_rdy", in_rdy, 1);
    chk("lit_reset_err", err_noncontig, 0);

    // Scatter four entries onto a sparse mask
    drive(8'h0F, 32'h0000_3210, 8'h00);
    tick();
    drive(8'h00, 32'h0, 8'hA5);
    @(negedge clk);
    chk("lit_t1_count", count, 4);
    chk("lit_t1_vld", out_vld, 8'hA5);
    chk("lit_t1_data", out_data, 32'h3020_0100);
    tick();
    drive(8'h00, 32'h0, 8'h00);
    @(negedge clk);
    chk("lit_t1_drained", count, 0);

    // Fewer entries than free slots
    drive(8'h07, 32'h0000_0765, 8'h00);
    tick();
    drive(8'h00, 32'h0, 8'hFF);
    @(negedge clk);
    chk("lit_t2_vld", out_vld, 8'h07);
    chk("lit_t2_data", out_data[11:0], 12'h765);
    tick();
    drive(8'h00, 32'h0, 8'h00);
    @(negedge clk);
    chk("lit_t2_count", count, 0);
    chk("lit_t2_rdy", in_rdy, 1);

    // Fill to full, ignored push, drain in order
    drive(8'hFF, 32'h7654_3210, 8'h00);
    tick();
    drive(8'hFF, 32'hFEDC_BA98, 8'h00);
    tick();
    drive(8'hFF, 32'h1111_1111, 8'h00);
    @(negedge clk);
    chk("lit_t3_full_count", count, 16);
    chk("lit_t3_full_rdy", in_rdy, 0);
    tick();
    drive(8'h00, 32'h0, 8'hFF);
    @(negedge clk);
    chk("lit_t3_ignored", count, 16);
    chk("lit_t3_data0", out_data, 32'h7654_3210);
    tick();
    @(negedge clk);
    chk("lit_t3_half_count", count, 8);
    chk("lit_t3_half_rdy", in_rdy, 1);
    chk("lit_t3_data1", out_data, 32'hFEDC_BA98);
    tick();

    // Simultaneous push and pop
    drive(8'h1F, 32'h0005_4321, 8'h00);
    tick();
    drive(8'h07, 32'h0000_0BA9, 8'h03);
    @(negedge clk);
    chk("lit_t4_count5", count, 5);
    chk("lit_t4_vld", out_vld, 8'h03);
    chk("lit_t4_data", out_data[7:0], 8'h21);
    tick();
    drive(8'h00, 32'h0, 8'hFF);
    @(negedge clk);
    chk("lit_t4_count6", count, 6);
    chk("lit_t4_vld2", out_vld, 8'h3F);
    chk("lit_t4_data2", out_data[23:0], 24'hBA_9543);
    tick();

    // Walk pointers to 14
    drive(8'hFF, 32'h0, 8'h00);
    tick();
    drive(8'h00, 32'h0, 8'hFF);
    tick();
    drive(8'h7F, 32'h0, 8'h00);
    tick();
    drive(8'h00, 32'h0, 8'h7F);
    tick();
    drive(8'h00, 32'h0, 8'h00);
    @(negedge clk);
    chk("lit_t5_head", dut.head_q, 14);
    chk("lit_t5_tail", dut.tail_q, 14);

    // Wrap-around write and scatter
    drive(8'h0F, 32'h0000_DCBA, 8'h00);
    tick();
    drive(8'h00, 32'h0, 8'hF0);
    @(negedge clk);
    chk("lit_t5_vld", out_vld, 8'hF0);
    chk("lit_t5_data", out_data, 32'hDCBA_0000);
    tick();

    // Non-contiguous valid mask, then reset mid-operation
    drive(8'h05, 32'h0000_0707, 8'h00);
    @(negedge clk);
    chk("lit_t6_rdy", in_rdy, 1);
    tick();
    drive(8'h00, 32'h0, 8'h00);
    @(negedge clk);
    chk("lit_t6_nowrite", count, 0);
    chk("lit_t6_err", err_noncontig, 1);
    tick();
    @(negedge clk);
    chk("lit_t6_sticky", err_noncontig, 1);
    drive(8'hFF, 32'h7654_3210, 8'h00);
    tick();
    drive(8'h01, 32'h0000_0008, 8'h00);
    tick();
    drive(8'h00, 32'h0, 8'hFF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_t6_count9", count, 9);
    chk("lit_t6_rst_vld", out_vld, 0);
    chk("lit_t6_rst_rdy", in_rdy, 0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    chk("lit_t6_post_count", count, 0);
    chk("lit_t6_post_err", err_noncontig, 0);
    chk("lit_t6_post_vld", out_vld, 0);
    tick();

    // Mixed traffic checked by the model
    for (int c = 0; c < 300; c++) begin
      int n;
      n = $urandom_range(0, NL);
      drive(8'((1 << n) - 1), $urandom, 8'($urandom));
      tick();
    end
    drive(8'h00, 32'h0, 8'h00);
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/expand_buffer.md
Name: expand_buffer

Overview:
- Inverse of the compaction network: buffers densely packed entries (valid prefix from lane 0) and scatters them, oldest first, onto a sparse set of destination slots given by a free mask.
- Sits between a compacted producer (e.g. the decode/rename group) and sparse consumer slots (issue-queue entries, RS rows).
- Circular buffer plus prefix-sum scatter network.
- Absorbs mismatches between group arrival and slot availability.

Parameters:
NUM_LANE, 8, lanes on both the packed input and the sparse output; power of two, >=2
DATA_SIZE, 4, bits per entry
BUF_DEPTH, 16, buffer entries; power of two, >= NUM_LANE

Ports:
clk  input  1  single clock, rising edge
rst_n  input  1  synchronous active-low reset
in_vld  input  NUM_LANE  packed valid mask; must be a contiguous prefix (bits 0..n-1)
in_data  input  NUM_LANE*DATA_SIZE  packed entries, lane i at [i*DATA_SIZE +: DATA_SIZE]
in_rdy  output  1  whole group accepted this cycle if in_rdy && |in_vld
slot_free  input  NUM_LANE  sparse mask of destination slots able to take one entry this cycle
out_vld  output  NUM_LANE  slot i receives out_data lane i this cycle (subset of slot_free)
out_data  output  NUM_LANE*DATA_SIZE  scattered entries
count  output  $clog2(BUF_DEPTH)+1  registered occupancy
err_noncontig  output  1  sticky protocol-violation flag

Behaviour:
- State: mem[BUF_DEPTH], head and tail pointers ($clog2(BUF_DEPTH) bits, wrap modulo BUF_DEPTH), count, err_noncontig.
- Reset:
  - Synchronous, while rst_n==0 at a clk edge: head=tail=count=0, err_noncontig=0. mem is not cleared.
  - During reset, in_rdy=0 and out_vld=0.
  - Reset mid-operation discards all buffered entries.
- in_rdy: combinational from registered count: (BUF_DEPTH - count) >= NUM_LANE. Never depends on in_vld or slot_free.
- Push:
  - n_in = popcount(in_vld), applied only when in_rdy && |in_vld && in_vld is contiguous.
  - Lane k is written to mem[(tail+k) mod BUF_DEPTH] for k < n_in; tail += n_in.
  - A push presented while in_rdy==0 is ignored; the producer must hold it.
- Contiguity check: in_vld is contiguous iff (in_vld & (in_vld+1)) == 0.
  - A violation while in_rdy is high: no write; err_noncontig set next edge and held until reset.
- Pop / scatter, combinational, zero latency from registered state and slot_free:
  - p_i = number of set bits of slot_free below i (exclusive prefix sum).
  - out_vld[i] = slot_free[i] && (p_i < count).
  - out_data lane i = mem[(head+p_i) mod BUF_DEPTH]. Don't-care when out_vld[i]=0; drive 0 for lint and sim cleanliness.
  - n_out = min(count, popcount(slot_free)); head += n_out.
- Ordering: oldest entry goes to the lowest-index free slot. Relative order is preserved across all slots and across wrap-around.
- Same-cycle push and pop:
  - count_next = count + n_in - n_out.
  - Entries pushed this cycle are not visible on out_* until the next cycle; no bypass.
- Boundaries:
  - count==0: out_vld=0 regardless of slot_free.
  - count==BUF_DEPTH: in_rdy=0; pops still proceed.
  - slot_free==0: no pop.
  - Pointer wrap is handled purely by modulo indexing.
- Widths:
  - Prefix sums and popcounts are $clog2(NUM_LANE)+1 bits.
  - Compare against count is zero-extended.
  - No arithmetic overflow is possible given the in_rdy rule.
- No FSM beyond occupancy; the sticky error bit is the only control state.
- Assertions in the bench: out_vld & ~slot_free == 0; count <= BUF_DEPTH; head+count == tail (mod BUF_DEPTH).

Decomposition:
- Shared package:
  - Lane-count / data-size defaults.
  - Pointer and count width constants (PTR_W = $clog2(BUF_DEPTH), CNT_W = PTR_W+1).
  - A popcount function shared with the compaction side.
- Sub-module: reuse the existing prefix_sum (INPUT_SIZE=1, OUTPUT_SIZE=$clog2(NUM_LANE)+1) on slot_free for p_i. The input side needs no network because it is already packed.
- Everything else stays in expand_buffer.

Test Plan:
- Reset, then push in_vld=8'h0F data {3,2,1,0}; next cycle slot_free=8'b1010_0101 -> out_vld=8'b1010_0101, slot0=0, slot2=1, slot5=2, slot7=3; count 4->0.
- count=3 holding {5,6,7}, slot_free=8'hFF -> out_vld=8'h07, slots 0..2 = 5,6,7; count=0; in_rdy stays 1.
- Push 8'hFF twice with slot_free=0 -> count=16, in_rdy=0; third push ignored, count stays 16; then slot_free=8'hFF -> 8 oldest out in order, count=8, in_rdy=1.
- count=5, push in_vld=8'h07, slot_free=8'h03 same cycle -> two oldest on slots 0,1; count=6 next cycle; new entries appear only after the older three.
- Pointers at head=tail=14, push 8'h0F values {A,B,C,D} (written to 14,15,0,1), slot_free=8'hF0 -> slots 4..7 = A,B,C,D.
- in_vld=8'b0000_0101 with in_rdy=1 -> no write, count unchanged, err_noncontig=1 and sticky. Then rst_n=0 for one cycle with count=9 -> count=0, out_vld=0, err_noncontig=0.
